// File: rtl/p_hazard_ctrl.sv
// p_hazard_ctrl: pipeline sequencer for the RV32IM 5-stage core.
// Drives the enable/flush controls of the PC, IF/ID, ID/EX and EX/MEM
// registers. It resolves load-use stalls, EX-stage redirects and multi-cycle
// mul/div operations. The mul/div handshake has a watchdog. Saturating stall
// and redirect counters are kept for performance monitoring.
module p_hazard_ctrl #(
   parameter int MULDIV_TIMEOUT = 64,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           i_id_rs1_addr,
   input  logic [4:0]           i_id_rs2_addr,
   input  logic                 i_id_uses_rs1,
   input  logic                 i_id_uses_rs2,
   input  logic                 i_ex_mem_read_en,
   input  logic [4:0]           i_ex_rd_addr,
   input  logic                 i_ex_redirect,
   input  logic                 i_ex_muldiv_req,
   input  logic                 i_muldiv_done,
   input  logic                 i_clr_counters,
   output logic                 o_muldiv_start,
   output logic                 o_pc_en,
   output logic                 o_if_id_en,
   output logic                 o_if_id_flush,
   output logic                 o_id_ex_en,
   output logic                 o_id_ex_flush,
   output logic                 o_ex_mem_en,
   output logic                 o_ex_mem_flush,
   output logic                 o_busy,
   output logic                 o_md_timeout,
   output logic [CNT_WIDTH-1:0] o_stall_cycles,
   output logic [CNT_WIDTH-1:0] o_flush_count
);

   // The watchdog only needs to reach MULDIV_TIMEOUT-1.
   localparam int WD_W = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULDIV_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MD_BUSY    = 2'd1,
      MD_RELEASE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            md_started;
   logic [WD_W-1:0] wd_cnt;
   logic            md_timeout_q;

   logic            rs1_hit;
   logic            rs2_hit;
   logic            load_use;
   logic            md_issue;
   logic            wd_at_last;
   logic            wd_expire;
   logic            redirect_evt;

   // Load-use, mul/div-issue and watchdog conditions seen this cycle.
   always_comb begin
      rs1_hit    = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
      rs2_hit    = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
      // x0 is never a real producer, so a load to x0 cannot create a hazard.
      load_use   = i_ex_mem_read_en && (i_ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
      // md_started blocks re-issue while the same operation is in flight.
      md_issue   = i_ex_muldiv_req && !md_started;
      wd_at_last = (wd_cnt == WD_LAST);
      // A done on the final watchdog cycle counts as a normal completion.
      wd_expire  = wd_at_last && !i_muldiv_done;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (md_issue) begin
               state_nxt = MD_BUSY;
            end
         end
         MD_BUSY: begin
            if (i_muldiv_done || wd_at_last) begin
               state_nxt = MD_RELEASE;
            end
         end
         MD_RELEASE: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // Mul/div handshake bookkeeping: in-flight flag, watchdog and sticky timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         md_started   <= 1'b0;
         wd_cnt       <= '0;
         md_timeout_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               wd_cnt <= '0;
               if (md_issue) begin
                  md_started <= 1'b1;
               end
            end
            MD_BUSY: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (wd_expire) begin
                  md_timeout_q <= 1'b1;
               end
            end
            MD_RELEASE: begin
               md_started <= 1'b0;
               wd_cnt     <= '0;
            end
            default: begin
               md_started <= 1'b0;
               wd_cnt     <= '0;
            end
         endcase
      end
   end

   // Pipeline register controls. Reset forces every stage to hold a bubble.
   always_comb begin
      o_muldiv_start = 1'b0;
      o_pc_en        = 1'b1;
      o_if_id_en     = 1'b1;
      o_if_id_flush  = 1'b0;
      o_id_ex_en     = 1'b1;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_en    = 1'b1;
      o_ex_mem_flush = 1'b0;
      redirect_evt   = 1'b0;
      if (!rst) begin
         o_pc_en        = 1'b0;
         o_if_id_en     = 1'b0;
         o_if_id_flush  = 1'b1;
         o_id_ex_en     = 1'b0;
         o_id_ex_flush  = 1'b1;
         o_ex_mem_en    = 1'b0;
         o_ex_mem_flush = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (md_issue) begin
                  // Freeze the front end and send a bubble past EX while
                  // the mul/div unit works on the operands held in ID/EX.
                  o_muldiv_start = 1'b1;
                  o_pc_en        = 1'b0;
                  o_if_id_en     = 1'b0;
                  o_id_ex_en     = 1'b0;
                  o_ex_mem_en    = 1'b0;
                  o_ex_mem_flush = 1'b1;
               end else if (i_ex_redirect) begin
                  // Younger instructions in IF/ID and ID/EX are on the
                  // wrong path. The redirecting instruction moves on.
                  o_if_id_flush  = 1'b1;
                  o_id_ex_flush  = 1'b1;
                  redirect_evt   = 1'b1;
               end else if (load_use) begin
                  // Hold IF and ID for one cycle and insert a single bubble.
                  // The load leaves EX next cycle and its data can be forwarded.
                  o_pc_en        = 1'b0;
                  o_if_id_en     = 1'b0;
                  o_id_ex_flush  = 1'b1;
               end
            end
            MD_BUSY: begin
               o_pc_en        = 1'b0;
               o_if_id_en     = 1'b0;
               o_id_ex_en     = 1'b0;
               o_ex_mem_en    = 1'b0;
               o_ex_mem_flush = 1'b1;
            end
            MD_RELEASE: begin
               // All stages advance, so EX/MEM captures the mul/div result.
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs.
   always_comb begin
      o_busy       = (state != RUN);
      o_md_timeout = md_timeout_q;
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_stall_cycles <= '0;
      end else if (i_clr_counters) begin
         o_stall_cycles <= '0;
      end else if (!o_pc_en && (o_stall_cycles != {CNT_WIDTH{1'b1}})) begin
         o_stall_cycles <= o_stall_cycles + 1'b1;
      end
   end

   // Saturating count of redirect flush events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_flush_count <= '0;
      end else if (i_clr_counters) begin
         o_flush_count <= '0;
      end else if (redirect_evt && (o_flush_count != {CNT_WIDTH{1'b1}})) begin
         o_flush_count <= o_flush_count + 1'b1;
      end
   end

endmodule
